framebuffer_pixel_stage: RTL and testbench



---
 rtl/framebuffer_pixel_stage.sv | 145 ++++++++++++++
 tb/tb_framebuffer_pixel_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_pixel_stage.sv
// Double-buffered RGB332 framebuffer scan-out stage, sync delayed to match pixel latency.
// Optional TEST_PATTERN_EN adds a test_pattern input that overrides memory data.
module framebuffer_pixel_stage #(
    parameter int unsigned H_PIX = 160,
    parameter int unsigned V_PIX = 120,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             wr_en,
    input  logic [7:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             swap_req,
`ifdef TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    output logic             swap_done,
    output logic             front_sel,
    output logic [PIX_W-1:0] rgb_out,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam logic [7:0]  H_LIM = 8'(H_PIX);
    localparam logic [7:0]  V_LIM = 8'(V_PIX);
    localparam logic [15:0] H_MUL = 16'(H_PIX);
    localparam int unsigned DEPTH = 2 * 65536;

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t           state_q, state_d;
    logic             front_q, front_d;
    logic             done_q, done_d;
    logic             vs_prev_q;
    logic             vfall;

    logic [15:0]      rd_addr, wr_addr;
    logic             rd_vis, wr_ok;

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_q;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             vis_q;
    logic [1:0]       hs_q, vs_q;
`ifdef TEST_PATTERN_EN
    logic [7:0]       x_q, y_q;
`endif

    assign rd_addr = 16'(y) * H_MUL + 16'(x);
    assign wr_addr = 16'(wr_y) * H_MUL + 16'(wr_x);
    assign rd_vis  = (x < H_LIM) && (y < V_LIM);
    assign wr_ok   = wr_en && (wr_x < H_LIM) && (wr_y < V_LIM);
    assign vfall   = vs_prev_q & ~vsync;

    // Writes target the buffer that is back before any swap on this edge.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[{~front_q, wr_addr}] <= wr_data;
        rd_q <= mem_q[{front_q, rd_addr}];
    end

    always_comb begin
        rgb_d = '0;
        if (vis_q) begin
            rgb_d = rd_q;
`ifdef TEST_PATTERN_EN
            if (test_pattern)
                rgb_d = PIX_W'({x_q[7:5], y_q[7:5], x_q[4:3]});
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vis_q     <= 1'b0;
            hs_q      <= 2'b11;
            vs_q      <= 2'b11;
            rgb_q     <= '0;
            vs_prev_q <= 1'b1;
`ifdef TEST_PATTERN_EN
            x_q       <= '0;
            y_q       <= '0;
`endif
        end else begin
            vis_q     <= rd_vis;
            hs_q      <= {hs_q[0], hsync};
            vs_q      <= {vs_q[0], vsync};
            rgb_q     <= rgb_d;
            vs_prev_q <= vsync;
`ifdef TEST_PATTERN_EN
            x_q       <= x;
            y_q       <= y;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    if (vfall) begin
                        front_d = ~front_q;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (vfall) begin
                    state_d = S_IDLE;
                    front_d = ~front_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            front_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            done_q  <= done_d;
        end
    end

    assign swap_done = done_q;
    assign front_sel = front_q;
    assign rgb_out   = rgb_q;
    assign hsync_out = hs_q[1];
    assign vsync_out = vs_q[1];

endmodule

// File: tb/tb_framebuffer_pixel_stage.sv
// Scoreboard testbench for framebuffer_pixel_stage.
// Build with TEST_PATTERN_EN defined to also exercise the test pattern input.
module tb_framebuffer_pixel_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x = 8'hFF, y = 8'hFF;
    logic       hsync = 1'b1, vsync = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_x = '0, wr_y = '0, wr_data = '0;
    logic       swap_req = 1'b0;
    logic       test_pattern = 1'b0;
    logic       swap_done, front_sel;
    logic [7:0] rgb_out;
    logic       hsync_out, vsync_out;

    framebuffer_pixel_stage dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .swap_req(swap_req),
`ifdef TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .swap_done(swap_done), .front_sel(front_sel),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         chk;
        logic [7:0] rgb;
        bit         hs;
        bit         vs;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [7:0] mdl [int];
    bit         mf = 1'b0;
    int         cyc = 0;
    int         ntests = 0;
    int         nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int key(bit b, logic [7:0] px, logic [7:0] py);
        return int'(b) * 65536 + int'(py) * 160 + int'(px);
    endfunction

    // Output monitor: pops the expectation due this cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            ntests++;
            if (e.due != cyc) begin
                nfail++;
                $display("FAIL sb_timing: due %0d got cycle %0d", e.due, cyc);
            end
            if (e.chk) begin
                ntests++;
                if (rgb_out !== e.rgb) begin
                    nfail++;
                    $display("FAIL rgb_out: got %h want %h (cyc %0d)", rgb_out, e.rgb, cyc);
                end
            end
            ntests++;
            if (hsync_out !== e.hs) begin
                nfail++;
                $display("FAIL hsync_out: got %b want %b (cyc %0d)", hsync_out, e.hs, cyc);
            end
            ntests++;
            if (vsync_out !== e.vs) begin
                nfail++;
                $display("FAIL vsync_out: got %b want %b (cyc %0d)", vsync_out, e.vs, cyc);
            end
        end
    end

    task automatic drive(input logic [7:0] px, input logic [7:0] py, input bit hs, input bit vs);
        logic [7:0] ev;
        bit         c;
        @(posedge clk);
        #1;
        x = px; y = py; hsync = hs; vsync = vs;
        wr_en = 1'b0; swap_req = 1'b0;
        c = 1'b1;
        ev = 8'h00;
        if (px < 8'd160 && py < 8'd120) begin
            if (test_pattern) ev = {px[7:5], py[7:5], px[4:3]};
            else if (mdl.exists(key(mf, px, py))) ev = mdl[key(mf, px, py)];
            else c = 1'b0;
        end
        sbq.push_back('{cyc + 2, c, ev, hs, vs});
    endtask

    task automatic wr(input logic [7:0] px, input logic [7:0] py, input logic [7:0] d);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        wr_en = 1'b1; wr_x = px; wr_y = py; wr_data = d;
        if (px < 8'd160 && py < 8'd120) mdl[key(~mf, px, py)] = d;
    endtask

    task automatic vfall(input bit req, input bit wen, input logic [7:0] px,
                         input logic [7:0] py, input logic [7:0] d);
        drive(8'hFF, 8'hFF, 1'b1, 1'b0);
        swap_req = req;
        if (wen) begin
            wr_en = 1'b1; wr_x = px; wr_y = py; wr_data = d;
            mdl[key(~mf, px, py)] = d;
        end
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic flush();
        int n = 0;
        while (sbq.size() > 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL flush_timeout: %0d pending want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic chk_swap(input string nm, input bit d, input bit f);
        @(negedge clk);
        ntests++;
        if (swap_done !== d) begin
            nfail++;
            $display("FAIL %s swap_done: got %b want %b", nm, swap_done, d);
        end
        ntests++;
        if (front_sel !== f) begin
            nfail++;
            $display("FAIL %s front_sel: got %b want %b", nm, front_sel, f);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ntests++;
        if (rgb_out !== 8'h00) begin
            nfail++; $display("FAIL rst_rgb: got %h want 00", rgb_out);
        end
        ntests++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            nfail++; $display("FAIL rst_sync: got %b%b want 11", hsync_out, vsync_out);
        end
        ntests++;
        if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
            nfail++; $display("FAIL rst_swap: got %b%b want 00", front_sel, swap_done);
        end
        reset = 1'b0;
        mf = 1'b0;
    endtask

    task automatic test_write_swap();
        wr(8'd5, 8'd7, 8'hE3);
        wr(8'd159, 8'd119, 8'h5A);
        wr(8'd0, 8'd0, 8'h81);
        wr(8'd0, 8'd1, 8'hFF);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        swap_req = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        chk_swap("pend_wait", 1'b0, 1'b0);
        vfall(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        mf = 1'b1;
        chk_swap("swap1", 1'b1, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        chk_swap("swap1_once", 1'b0, 1'b1);
        drive(8'd5, 8'd7, 1'b1, 1'b1);
        drive(8'd159, 8'd119, 1'b1, 1'b1);
        drive(8'd0, 8'd0, 1'b1, 1'b1);
        drive(8'd0, 8'd1, 1'b1, 1'b1);
        flush();
    endtask

    task automatic test_blanking();
        drive(8'd160, 8'd0, 1'b1, 1'b1);
        drive(8'd0, 8'd120, 1'b1, 1'b1);
        drive(8'd0, 8'd1, 1'b1, 1'b1);
        drive(8'd200, 8'd250, 1'b1, 1'b1);
        flush();
    endtask

    task automatic test_sync();
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        drive(8'hFF, 8'hFF, 1'b0, 1'b1);
        drive(8'hFF, 8'hFF, 1'b0, 1'b0);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        drive(8'd5, 8'd7, 1'b0, 1'b1);
        flush();
    endtask

    task automatic test_double_swap();
        wr(8'd2, 8'd2, 8'h22);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        swap_req = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        swap_req = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        chk_swap("dbl_wait", 1'b0, 1'b1);
        vfall(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        mf = 1'b0;
        chk_swap("dbl_swap", 1'b1, 1'b0);
        vfall(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_swap("dbl_absorb", 1'b0, 1'b0);
        drive(8'd2, 8'd2, 1'b1, 1'b1);
        flush();
    endtask

    task automatic test_edge_swap();
        wr(8'd2, 8'd2, 8'h11);
        vfall(1'b1, 1'b1, 8'd2, 8'd2, 8'h3C);
        mf = 1'b1;
        chk_swap("edge_swap", 1'b1, 1'b1);
        drive(8'd2, 8'd2, 1'b1, 1'b1);
        drive(8'd5, 8'd7, 1'b1, 1'b1);
        flush();
    endtask

    task automatic test_oob_write();
        wr(8'd40, 8'd1, 8'hAA);
        wr(8'd0, 8'd1, 8'hBB);
        wr(8'd200, 8'd0, 8'h77);
        wr(8'd160, 8'd0, 8'h66);
        wr(8'd0, 8'd120, 8'h55);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        swap_req = 1'b1;
        vfall(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        mf = 1'b0;
        chk_swap("oob_swap", 1'b1, 1'b0);
        drive(8'd40, 8'd1, 1'b1, 1'b1);
        drive(8'd0, 8'd1, 1'b1, 1'b1);
        drive(8'd2, 8'd2, 1'b1, 1'b1);
        flush();
    endtask

    task automatic test_reset_pending();
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        swap_req = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        flush();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mf = 1'b0;
        chk_swap("rst_front", 1'b0, 1'b0);
        vfall(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_swap("rst_nopend", 1'b0, 1'b0);
        flush();
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern_gen();
        test_pattern = 1'b1;
        drive(8'h48, 8'h20, 1'b1, 1'b1);
        drive(8'hA0, 8'h60, 1'b1, 1'b1);
        drive(8'h9F, 8'h77, 1'b1, 1'b1);
        flush();
        test_pattern = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_swap();
        test_blanking();
        test_sync();
        test_double_swap();
        test_edge_swap();
        test_oob_write();
        test_reset_pending();
`ifdef TEST_PATTERN_EN
        test_pattern_gen();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
